// File: rtl/id_exe_pipe_if.sv
// ID/EXE handshake bundle: decode-side capture port and EXE-side issue port.
// slave = pipeline register, master = decode/EXE environment.
interface id_exe_pipe_if #(
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 8,
   parameter int RADDR_W = 5
);
   logic               flush_i_IDEXE;
   logic               valid_i_IDEXE;
   logic               ready_o_IDEXE;
   logic               regWrite_i_IDEXE;
   logic [ALUOP_W-1:0] ALUOp_i_IDEXE;
   logic [RADDR_W-1:0] rd_i_IDEXE;
   logic [DATA_W-1:0]  rs1Data_i_IDEXE;
   logic [DATA_W-1:0]  imm_i_IDEXE;
   logic [DATA_W-1:0]  pc_i_IDEXE;
   logic               valid_o_IDEXE;
   logic               ready_i_IDEXE;
   logic               regWrite_o_IDEXE;
   logic [ALUOP_W-1:0] ALUOp_o_IDEXE;
   logic [RADDR_W-1:0] rd_o_IDEXE;
   logic [DATA_W-1:0]  rs1Data_o_IDEXE;
   logic [DATA_W-1:0]  imm_o_IDEXE;
   logic [DATA_W-1:0]  pc_o_IDEXE;
   logic [31:0]        bubbleCnt_o_IDEXE;

   modport slave (
      input  flush_i_IDEXE, valid_i_IDEXE, regWrite_i_IDEXE,
      input  ALUOp_i_IDEXE, rd_i_IDEXE, rs1Data_i_IDEXE,
      input  imm_i_IDEXE, pc_i_IDEXE, ready_i_IDEXE,
      output ready_o_IDEXE, valid_o_IDEXE, regWrite_o_IDEXE,
      output ALUOp_o_IDEXE, rd_o_IDEXE, rs1Data_o_IDEXE,
      output imm_o_IDEXE, pc_o_IDEXE, bubbleCnt_o_IDEXE
   );

   modport master (
      output flush_i_IDEXE, valid_i_IDEXE, regWrite_i_IDEXE,
      output ALUOp_i_IDEXE, rd_i_IDEXE, rs1Data_i_IDEXE,
      output imm_i_IDEXE, pc_i_IDEXE, ready_i_IDEXE,
      input  ready_o_IDEXE, valid_o_IDEXE, regWrite_o_IDEXE,
      input  ALUOp_o_IDEXE, rd_o_IDEXE, rs1Data_o_IDEXE,
      input  imm_o_IDEXE, pc_o_IDEXE, bubbleCnt_o_IDEXE
   );
endinterface

// File: rtl/id_exe_pipe.sv
// ID/EXE pipeline register: 2-entry skid buffer (main M + skid S),
// flush/reset kill, bubble squash and a bubble-cycle counter.
module id_exe_pipe #(
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 8,
   parameter int RADDR_W = 5
) (
   input logic          clk_i_IDEXE,
   input logic          rst_i_IDEXE,
   id_exe_pipe_if.slave bus
);
   typedef struct packed {
      logic               rw;
      logic [ALUOP_W-1:0] op;
      logic [RADDR_W-1:0] rd;
      logic [DATA_W-1:0]  rs1;
      logic [DATA_W-1:0]  imm;
      logic [DATA_W-1:0]  pc;
   } pl_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd3
   } state_t;

   state_t      state_q;
   pl_t         m_q;
   pl_t         s_q;
   pl_t         in_pl;
   logic [31:0] bubble_q;
   logic        in_fire;
   logic        out_fire;

   assign in_pl = '{
      rw:  bus.regWrite_i_IDEXE,
      op:  bus.ALUOp_i_IDEXE,
      rd:  bus.rd_i_IDEXE,
      rs1: bus.rs1Data_i_IDEXE,
      imm: bus.imm_i_IDEXE,
      pc:  bus.pc_i_IDEXE
   };

   // ready depends only on held state and reset, never on ready_i
   assign bus.ready_o_IDEXE = (state_q != FULL) & ~rst_i_IDEXE;
   assign bus.valid_o_IDEXE = (state_q != EMPTY);

   assign in_fire  = bus.valid_i_IDEXE & bus.ready_o_IDEXE;
   assign out_fire = bus.valid_o_IDEXE & bus.ready_i_IDEXE;

   always_ff @(posedge clk_i_IDEXE) begin
      if (rst_i_IDEXE) begin
         state_q  <= EMPTY;
         m_q      <= '0;
         s_q      <= '0;
         bubble_q <= '0;
      end else begin
         if (!bus.valid_o_IDEXE) bubble_q <= bubble_q + 32'd1;
         if (bus.flush_i_IDEXE) begin
            state_q <= EMPTY;
         end else begin
            unique case (state_q)
               EMPTY: begin
                  if (in_fire) begin
                     m_q     <= in_pl;
                     state_q <= ONE;
                  end
               end
               ONE: begin
                  if (in_fire && out_fire) begin
                     m_q <= in_pl;
                  end else if (in_fire) begin
                     s_q     <= in_pl;
                     state_q <= FULL;
                  end else if (out_fire) begin
                     state_q <= EMPTY;
                  end
               end
               FULL: begin
                  if (out_fire) begin
                     m_q     <= s_q;
                     state_q <= ONE;
                  end
               end
               default: state_q <= EMPTY;
            endcase
         end
      end
   end

   assign bus.regWrite_o_IDEXE  = m_q.rw & bus.valid_o_IDEXE;
   assign bus.ALUOp_o_IDEXE     = bus.valid_o_IDEXE ? m_q.op : '0;
   assign bus.rd_o_IDEXE        = m_q.rd;
   assign bus.rs1Data_o_IDEXE   = m_q.rs1;
   assign bus.imm_o_IDEXE       = m_q.imm;
   assign bus.pc_o_IDEXE        = m_q.pc;
   assign bus.bubbleCnt_o_IDEXE = bubble_q;
endmodule

// File: tb/tb_id_exe_pipe.sv
// Scoreboard bench for id_exe_pipe: queue model of accepted, unkilled
// instructions drives all expectations for handshake, payload and counter.
module tb_id_exe_pipe;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int RW = 5;
   localparam logic [7:0] ADDI = 8'h13;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   id_exe_pipe_if #(.DATA_W(DW), .ALUOP_W(AW), .RADDR_W(RW)) bus ();

   id_exe_pipe #(.DATA_W(DW), .ALUOP_W(AW), .RADDR_W(RW)) dut (
      .clk_i_IDEXE (clk),
      .rst_i_IDEXE (rst),
      .bus         (bus.slave)
   );

   typedef struct {
      logic          rw;
      logic [AW-1:0] op;
      logic [RW-1:0] rd;
      logic [DW-1:0] rs1;
      logic [DW-1:0] imm;
      logic [DW-1:0] pc;
   } item_t;

   item_t       q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] exp_cnt = '0;
   bit          rst_prev = 1'b1;
   bit          force_req = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", nm, act, exp);
   endtask

   initial begin
      bus.flush_i_IDEXE    = 1'b0;
      bus.valid_i_IDEXE    = 1'b1;
      bus.regWrite_i_IDEXE = 1'b1;
      bus.ALUOp_i_IDEXE    = ADDI;
      bus.rd_i_IDEXE       = 5'd31;
      bus.rs1Data_i_IDEXE  = 32'hDEAD_BEEF;
      bus.imm_i_IDEXE      = 32'h1234_5678;
      bus.pc_i_IDEXE       = 32'h0000_1000;
      bus.ready_i_IDEXE    = 1'b0;
   end

   // Monitor: compares against the queue model every cycle.
   initial begin
      item_t e;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (force_req) exp_cnt = 32'hFFFF_FFFF;
         chk("ready_o", {31'd0, bus.ready_o_IDEXE},
             {31'd0, (!rst && q.size() < 2)});
         chk("valid_o", {31'd0, bus.valid_o_IDEXE},
             {31'd0, (q.size() > 0)});
         chk("bubbleCnt", bus.bubbleCnt_o_IDEXE, exp_cnt);
         if (!bus.valid_o_IDEXE) begin
            chk("squash_rw", {31'd0, bus.regWrite_o_IDEXE}, 32'd0);
            chk("squash_op", {24'd0, bus.ALUOp_o_IDEXE}, 32'd0);
         end
         if (rst_prev) begin
            chk("rst_rd", {27'd0, bus.rd_o_IDEXE}, 32'd0);
            chk("rst_rs1", bus.rs1Data_o_IDEXE, 32'd0);
            chk("rst_imm", bus.imm_o_IDEXE, 32'd0);
            chk("rst_pc", bus.pc_o_IDEXE, 32'd0);
         end
         if (bus.valid_o_IDEXE && bus.ready_i_IDEXE && q.size() > 0) begin
            e = q.pop_front();
            chk("out_rw", {31'd0, bus.regWrite_o_IDEXE}, {31'd0, e.rw});
            chk("out_op", {24'd0, bus.ALUOp_o_IDEXE}, {24'd0, e.op});
            chk("out_rd", {27'd0, bus.rd_o_IDEXE}, {27'd0, e.rd});
            chk("out_rs1", bus.rs1Data_o_IDEXE, e.rs1);
            chk("out_imm", bus.imm_o_IDEXE, e.imm);
            chk("out_pc", bus.pc_o_IDEXE, e.pc);
         end
         rst_prev = rst;
         if (rst) begin
            q.delete();
            exp_cnt = '0;
         end else begin
            if (!bus.valid_o_IDEXE) exp_cnt = exp_cnt + 32'd1;
            if (bus.flush_i_IDEXE) q.delete();
         end
      end
   end

   task automatic cyc(input bit r, input bit fl, input bit v,
                      input bit rdy, input bit rw,
                      input logic [AW-1:0] op, input logic [RW-1:0] rd,
                      input logic [DW-1:0] d, input logic [DW-1:0] imm,
                      input logic [DW-1:0] pc);
      @(posedge clk);
      #1;
      rst = r;
      bus.flush_i_IDEXE    = fl;
      bus.valid_i_IDEXE    = v;
      bus.ready_i_IDEXE    = rdy;
      bus.regWrite_i_IDEXE = rw;
      bus.ALUOp_i_IDEXE    = op;
      bus.rd_i_IDEXE       = rd;
      bus.rs1Data_i_IDEXE  = d;
      bus.imm_i_IDEXE      = imm;
      bus.pc_i_IDEXE       = pc;
      @(negedge clk);
      #1;
      if (v && bus.ready_o_IDEXE && !r && !fl)
         q.push_back('{rw, op, rd, d, imm, pc});
   endtask

   task automatic idle(input bit rdy, input int n);
      for (int i = 0; i < n; i++)
         cyc(0, 0, 0, rdy, 1, ADDI, 5'd0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic send(input bit rdy, input bit fl, input logic [RW-1:0] rd);
      cyc(0, fl, 1, rdy, 1, ADDI, rd, $urandom, {27'd0, rd},
          32'h100 + {25'd0, rd, 2'b00});
   endtask

   initial begin
      // reset held two cycles while decode presents an instruction
      cyc(1, 0, 1, 0, 1, ADDI, 5'd31, 32'hDEAD_BEEF, 32'h1, 32'h1000);
      cyc(1, 0, 1, 0, 1, ADDI, 5'd31, 32'hDEAD_BEEF, 32'h1, 32'h1000);
      idle(1, 3);
      // streaming
      for (int i = 1; i <= 4; i++) send(1, 0, i[4:0]);
      idle(1, 2);
      // backpressure into FULL, then drain in order
      send(0, 0, 5'd5);
      send(0, 0, 5'd6);
      send(0, 0, 5'd7);
      send(1, 0, 5'd7);
      send(1, 0, 5'd7);
      idle(1, 3);
      // flush while FULL with a new instruction presented
      send(0, 0, 5'd8);
      send(0, 0, 5'd10);
      send(0, 1, 5'd9);
      idle(1, 3);
      // simultaneous in/out while ONE
      send(1, 0, 5'd3);
      send(1, 0, 5'd4);
      idle(1, 2);
      // counter wrap
      @(posedge clk);
      #1;
      force dut.bubble_q = 32'hFFFF_FFFF;
      force_req = 1'b1;
      @(negedge clk);
      #1;
      release dut.bubble_q;
      force_req = 1'b0;
      idle(1, 2);
      // randomized traffic with occasional flush and reset
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 9) < 6),
             $urandom_range(0, 1),
             $urandom, $urandom, $urandom, $urandom, $urandom);
      end
      idle(1, 4);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/id_exe_pipe.md
Name: id_exe_pipe

Overview:
- Decode-to-Execute pipeline register; sits directly downstream of the decode control unit and feeds the EXE ALU.
- Captures decoded control (regWrite, ALUOp) plus operands and destination, with a valid/ready handshake on both sides.
- Implemented as a 2-entry skid buffer so EXE backpressure never drops an instruction and upstream ready is registered-path only.
- Flush input kills in-flight entries for branch/exception redirect.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- ALUOP_W, 8, width of ALUOp field (matches ALUOpBus)
- RADDR_W, 5, register-file address width

Ports:
- clk_i_IDEXE  in  1  clock, rising edge
- rst_i_IDEXE  in  1  synchronous reset, active-high (RstEnable = 1)
- flush_i_IDEXE  in  1  kill all held entries this cycle
- valid_i_IDEXE  in  1  decode presents an instruction
- ready_o_IDEXE  out  1  this block can accept an instruction
- regWrite_i_IDEXE  in  1  from control unit
- ALUOp_i_IDEXE  in  ALUOP_W  from control unit
- rd_i_IDEXE  in  RADDR_W  destination register
- rs1Data_i_IDEXE  in  DATA_W  operand 1 from regfile
- imm_i_IDEXE  in  DATA_W  sign-extended immediate
- pc_i_IDEXE  in  DATA_W  instruction PC
- valid_o_IDEXE  out  1  EXE-side instruction valid
- ready_i_IDEXE  in  1  EXE accepts
- regWrite_o_IDEXE  out  1
- ALUOp_o_IDEXE  out  ALUOP_W
- rd_o_IDEXE  out  RADDR_W
- rs1Data_o_IDEXE  out  DATA_W
- imm_o_IDEXE  out  DATA_W
- pc_o_IDEXE  out  DATA_W
- bubbleCnt_o_IDEXE  out  32  count of cycles with valid_o=0 (performance)

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S; each has a valid bit.
- Transfer in: valid_i & ready_o. Transfer out: valid_o & ready_i. valid_o = M.valid.
- ready_o = !S.valid & !rst_i (registered-state only; no combinational path from ready_i).
- States by (M.valid,S.valid): EMPTY(0,0), ONE(1,0), FULL(1,1). (0,1) unreachable.
- EMPTY: in -> M loaded, ONE.
- ONE: in & out -> M reloaded with new, stay ONE. in & !out -> new into S, FULL. out & !in -> EMPTY. neither -> hold.
- FULL: ready_o=0, inputs ignored. out -> S moves to M, S cleared, ONE. else hold.
- Order preserved: S is always younger than M.
- Latency: 1 cycle from accepted input to valid_o when EMPTY or ONE-with-drain.
- Bubble squash: whenever valid_o=0, regWrite_o=0 and ALUOp_o=ZeroALUOp (all zero); other payload outputs hold last value (don't-care).
- Flush: M.valid and S.valid cleared next edge; an input presented in the same cycle is dropped (flush wins over capture); regWrite_o=0 from next cycle. ready_o=1 the cycle after flush.
- Reset (sync, rst_i=1 at edge): M/S invalid, all payload outputs 0, ALUOp_o=ZeroALUOp, regWrite_o=0, valid_o=0, bubbleCnt_o=0; ready_o=0 while rst_i asserted. Reset mid-FULL discards both entries. Reset beats flush.
- bubbleCnt_o: increments by 1 each non-reset cycle where valid_o=0 at the edge; wraps 0xFFFF_FFFF -> 0.
- Payload captured verbatim; no arithmetic on data.

Test Plan:
- Reset: hold rst_i 2 cycles with valid_i=1 -> valid_o=0, regWrite_o=0, ALUOp_o=0, ready_o=0; after release ready_o=1, bubbleCnt_o counts 1,2,...
- Streaming: ready_i=1, 4 back-to-back ADDI (ALUOp=ADDI, rd=1..4, imm=1..4) -> valid_o from cycle+1, rd_o 1,2,3,4 consecutively, regWrite_o=1, no bubbles.
- Backpressure: ready_i=0 and send rd=5 then rd=6 -> FULL, ready_o=0, rd=7 held upstream; raise ready_i -> outputs rd 5,6,7 in order, none lost or duplicated.
- Flush in FULL with valid_i=1 (rd=9) -> next cycle valid_o=0, regWrite_o=0, ready_o=1; rd=9 never appears.
- Simultaneous in/out in ONE: M=rd 3, ready_i=1, input rd 4 -> next cycle M=rd 4, S empty, ready_o=1.
- Counter wrap: force bubbleCnt to 0xFFFF_FFFF, one idle cycle -> 0x0000_0000.
